// File: rtl/otter_io_pkg.sv
// ============================================================================
// otter_io_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the OTTER memory-mapped I/O responder.
//           Holds the register byte offsets inside the I/O window, the CTRL
//           and STATUS bit positions, the packed CTRL struct and a helper
//           that reduces a bus address to its word-aligned window offset.
// Ports   : none (package).
// ============================================================================
package otter_io_pkg;

    // Byte offsets of each register inside the 256-byte I/O window.
    localparam logic [7:0] IO_SW_OFS   = 8'h00;
    localparam logic [7:0] IO_BTN_OFS  = 8'h04;
    localparam logic [7:0] IO_LED_OFS  = 8'h20;
    localparam logic [7:0] IO_TCMP_OFS = 8'h40;
    localparam logic [7:0] IO_TCNT_OFS = 8'h44;
    localparam logic [7:0] IO_CTRL_OFS = 8'h48;
    localparam logic [7:0] IO_STAT_OFS = 8'h4C;

    // CTRL bit positions.
    localparam int CTRL_TEN_BIT = 0;
    localparam int CTRL_TAR_BIT = 1;
    localparam int CTRL_TIE_BIT = 2;
    localparam int CTRL_BIE_BIT = 3;

    // STATUS bit positions.
    localparam int STAT_TPEND_BIT = 0;
    localparam int STAT_BPEND_LSB = 4;

    // CTRL register layout, MSB first so the struct maps directly onto
    // bits [3:0] of the bus word.
    typedef struct packed {
        logic bie;
        logic tie;
        logic tar;
        logic ten;
    } io_ctrl_t;

    // Byte lanes are ignored: only ADDR[7:2] selects a register.
    function automatic logic [7:0] wordOffset(input logic [31:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_io_timer.sv
// ============================================================================
// otter_io_timer
// ----------------------------------------------------------------------------
// Purpose : 32-bit compare timer for the OTTER I/O responder. Holds the
//           prescaler, the TCMP and TCNT registers and the match detector.
//           Only built when OTTER_IO_TIMER_EN is defined in the top level.
// Params  : PRESCALE     - CLK cycles per timer tick (1 .. 65535).
// Ports   : CLK          - system clock.
//           RESET        - asynchronous active-high reset.
//           i_en         - CTRL.TEN, runs the prescaler and counter.
//           i_autoReload - CTRL.TAR, count returns to 0 on a match.
//           i_loadCmp    - bus store to TCMP this cycle.
//           i_loadCnt    - bus store to TCNT this cycle.
//           i_wdata      - store data from the CPU.
//           o_tcnt       - current count.
//           o_tcmp       - current compare value.
//           o_match      - tick this cycle with the pre-increment count equal
//                          to TCMP; the top level latches it into TPEND.
// ============================================================================
module otter_io_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_en,
    input  logic        i_autoReload,
    input  logic        i_loadCmp,
    input  logic        i_loadCnt,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_tcnt,
    output logic [31:0] o_tcmp,
    output logic        o_match
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_pre;
    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    logic        w_tick;

    // A tick is the last prescaler cycle while enabled; matching compares
    // the count before it is incremented on that tick.
    assign w_tick  = i_en && (r_pre == PRE_LAST);
    assign o_match = w_tick && (r_tcnt == r_tcmp);
    assign o_tcnt  = r_tcnt;
    assign o_tcmp  = r_tcmp;

    // Prescaler: counts 0..PRESCALE-1 while enabled and is held at 0 while
    // disabled, so re-enabling always starts a full tick period.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pre <= '0;
        end else if (!i_en || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // Counter: a bus store has priority over a tick in the same cycle. The
    // match of that cycle has already been evaluated on the old count.
    // Natural 32-bit overflow provides the wrap from FFFF_FFFF to 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tcnt <= '0;
        end else if (i_loadCnt) begin
            r_tcnt <= i_wdata;
        end else if (w_tick) begin
            if (o_match && i_autoReload) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 32'd1;
            end
        end
    end

    // Compare register, written only from the bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tcmp <= '0;
        end else if (i_loadCmp) begin
            r_tcmp <= i_wdata;
        end
    end

endmodule

// File: rtl/otter_io_responder.sv
// ============================================================================
// otter_io_responder
// ----------------------------------------------------------------------------
// Purpose : Memory-mapped I/O responder at the far end of the OTTER IOBUS.
//           Exposes switches and buttons (2-flop synchronized), an LED
//           register, an optional compare timer and a latched, maskable
//           pending-event register that drives the CPU INTR line.
// Config  : `define OTTER_IO_TIMER_EN to build the timer (TCMP, TCNT,
//           CTRL[2:0], TPEND). Without it those read 0, ignore writes and
//           no timer flops exist; INTR then comes from buttons only.
// Params  : BASE_ADDR  - window base, only bits [31:8] are compared.
//           PRESCALE   - CLK cycles per timer tick (1 .. 65535).
// Ports   : CLK        - system clock.
//           RESET      - asynchronous active-high reset.
//           IOBUS_ADDR - byte address from the CPU.
//           IOBUS_OUT  - store data from the CPU.
//           IOBUS_WR   - store strobe.
//           IOBUS_IN   - registered read data, valid the cycle after ADDR.
//           SWITCHES   - asynchronous board switches.
//           BTN        - asynchronous board buttons.
//           LEDS       - LED register.
//           INTR       - level interrupt request.
// ============================================================================
module otter_io_responder
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    input  logic [15:0] SWITCHES,
    input  logic [3:0]  BTN,
    output logic [15:0] LEDS,
    output logic        INTR
);

    logic [15:0] r_swMeta;
    logic [15:0] r_swSync;
    logic [3:0]  r_btnMeta;
    logic [3:0]  r_btnSync;
    logic [3:0]  r_btnPrev;
    logic [3:0]  r_bpend;
    logic [15:0] r_leds;
    logic        r_bie;
    logic [31:0] r_iobusIn;

    logic        w_hit;
    logic        w_wr;
    logic [7:0]  w_ofs;
    logic [3:0]  w_btnRise;
    logic        w_statW1c;
    logic [31:0] w_rdata;
    io_ctrl_t    w_ctrl;
    logic        w_tpend;
    logic [31:0] w_tcntRd;
    logic [31:0] w_tcmpRd;
    logic        w_unused;

    assign w_hit     = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign w_wr      = IOBUS_WR && w_hit;
    assign w_ofs     = wordOffset(IOBUS_ADDR);
    assign w_statW1c = w_wr && (w_ofs == IO_STAT_OFS);
    assign w_btnRise = r_btnSync & ~r_btnPrev;

    // Address byte lanes are ignored by design; the remaining store bits
    // only matter for some registers depending on the build.
    assign w_unused  = ^{IOBUS_ADDR[1:0], IOBUS_OUT, (PRESCALE == 0)};

    // Two-flop synchronizers for the board inputs plus one extra button
    // stage used for rising-edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_swMeta  <= '0;
            r_swSync  <= '0;
            r_btnMeta <= '0;
            r_btnSync <= '0;
            r_btnPrev <= '0;
        end else begin
            r_swMeta  <= SWITCHES;
            r_swSync  <= r_swMeta;
            r_btnMeta <= BTN;
            r_btnSync <= r_btnMeta;
            r_btnPrev <= r_btnSync;
        end
    end

    // LED register and the button-interrupt enable, both plain bus stores.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_leds <= '0;
            r_bie  <= 1'b0;
        end else begin
            if (w_wr && (w_ofs == IO_LED_OFS)) begin
                r_leds <= IOBUS_OUT[15:0];
            end
            if (w_wr && (w_ofs == IO_CTRL_OFS)) begin
                r_bie <= IOBUS_OUT[CTRL_BIE_BIT];
            end
        end
    end

    // Button pending bits: write-1-to-clear, but a rising edge in the same
    // cycle wins so no event is lost. They latch regardless of BIE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bpend <= '0;
        end else begin
            r_bpend <= (r_bpend & ~(w_statW1c ? IOBUS_OUT[STAT_BPEND_LSB +: 4] : 4'b0))
                       | w_btnRise;
        end
    end

`ifdef OTTER_IO_TIMER_EN
    logic        r_ten;
    logic        r_tar;
    logic        r_tie;
    logic        r_tpend;
    logic [31:0] w_tcnt;
    logic [31:0] w_tcmp;
    logic        w_match;

    // Timer-related CTRL bits and the timer pending bit. As with buttons,
    // a match in the same cycle as a W1C keeps TPEND set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ten   <= 1'b0;
            r_tar   <= 1'b0;
            r_tie   <= 1'b0;
            r_tpend <= 1'b0;
        end else begin
            if (w_wr && (w_ofs == IO_CTRL_OFS)) begin
                r_ten <= IOBUS_OUT[CTRL_TEN_BIT];
                r_tar <= IOBUS_OUT[CTRL_TAR_BIT];
                r_tie <= IOBUS_OUT[CTRL_TIE_BIT];
            end
            r_tpend <= (r_tpend & ~(w_statW1c & IOBUS_OUT[STAT_TPEND_BIT])) | w_match;
        end
    end

    otter_io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_en         (r_ten),
        .i_autoReload (r_tar),
        .i_loadCmp    (w_wr && (w_ofs == IO_TCMP_OFS)),
        .i_loadCnt    (w_wr && (w_ofs == IO_TCNT_OFS)),
        .i_wdata      (IOBUS_OUT),
        .o_tcnt       (w_tcnt),
        .o_tcmp       (w_tcmp),
        .o_match      (w_match)
    );

    assign w_ctrl.bie = r_bie;
    assign w_ctrl.tie = r_tie;
    assign w_ctrl.tar = r_tar;
    assign w_ctrl.ten = r_ten;
    assign w_tpend    = r_tpend;
    assign w_tcntRd   = w_tcnt;
    assign w_tcmpRd   = w_tcmp;
`else
    assign w_ctrl.bie = r_bie;
    assign w_ctrl.tie = 1'b0;
    assign w_ctrl.tar = 1'b0;
    assign w_ctrl.ten = 1'b0;
    assign w_tpend    = 1'b0;
    assign w_tcntRd   = '0;
    assign w_tcmpRd   = '0;
`endif

    // Read mux: anything outside the window or at an unmapped offset is 0.
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_ofs)
                IO_SW_OFS:   w_rdata = {16'b0, r_swSync};
                IO_BTN_OFS:  w_rdata = {28'b0, r_btnSync};
                IO_LED_OFS:  w_rdata = {16'b0, r_leds};
                IO_TCMP_OFS: w_rdata = w_tcmpRd;
                IO_TCNT_OFS: w_rdata = w_tcntRd;
                IO_CTRL_OFS: w_rdata = {28'b0, w_ctrl};
                IO_STAT_OFS: w_rdata = {24'b0, r_bpend, 3'b0, w_tpend};
                default:     w_rdata = '0;
            endcase
        end
    end

    // Read data is registered every cycle to match the CPU's one-cycle
    // synchronous memory latency.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_iobusIn <= '0;
        end else begin
            r_iobusIn <= w_rdata;
        end
    end

    assign IOBUS_IN = r_iobusIn;
    assign LEDS     = r_leds;
    assign INTR     = (w_tpend & w_ctrl.tie) | ((|r_bpend) & w_ctrl.bie);

endmodule

// File: tb/tb_otter_io_responder.sv
// ============================================================================
// tb_otter_io_responder
// ----------------------------------------------------------------------------
// Purpose : Directed self-checking bench for otter_io_responder. Bus cycles
//           are launched on the falling edge and outputs are sampled on the
//           following falling edge, so registered read data and register
//           side effects from the intervening rising edge are visible.
// ============================================================================
module tb_otter_io_responder;
    import otter_io_pkg::*;

    localparam logic [31:0] BASE = 32'h1100_0000;

    logic        CLK;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES;
    logic [3:0]  BTN;
    logic [15:0] LEDS;
    logic        INTR;

    int total = 0;
    int bad   = 0;

    otter_io_responder #(
        .BASE_ADDR (BASE),
        .PRESCALE  (1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .BTN        (BTN),
        .LEDS       (LEDS),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ioAddr(input logic [7:0] ofs);
        return {BASE[31:8], ofs};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle, started and finished on a falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wr);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = wr;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(addr, 32'h0, 1'b0);
        checkOutput(tag, IOBUS_IN, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RESET      = 1'b1;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        SWITCHES   = '0;
        BTN        = '0;
        idle(2);
        checkOutput("reset_iobus_in", IOBUS_IN, 32'h0);
        checkOutput("reset_leds", {16'b0, LEDS}, 32'h0);
        checkOutput("reset_intr", {31'b0, INTR}, 32'h0);
        RESET = 1'b0;

        // Switches, byte-lane ignore, unmapped and out-of-window reads.
        SWITCHES = 16'hA5C3;
        idle(3);
        readCheck("sw_read", ioAddr(IO_SW_OFS), 32'h0000_A5C3);
        readCheck("sw_lowbits", ioAddr(8'h03), 32'h0000_A5C3);
        readCheck("unmapped", ioAddr(8'h10), 32'h0);
        readCheck("out_of_window", 32'h1200_0000, 32'h0);

        // Buttons read, then release and clear the pending bits they set.
        BTN = 4'b1010;
        idle(3);
        readCheck("btn_read", ioAddr(IO_BTN_OFS), 32'h0000_000A);
        BTN = 4'b0000;
        idle(3);
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h0000_00F0, 1'b1);
        readCheck("status_cleared", ioAddr(IO_STAT_OFS), 32'h0);

        // LEDs: store, read back, out-of-window store, read-only store.
        applyStimulus(ioAddr(IO_LED_OFS), 32'h0000_BEEF, 1'b1);
        checkOutput("leds_store", {16'b0, LEDS}, 32'h0000_BEEF);
        readCheck("leds_read", ioAddr(IO_LED_OFS), 32'h0000_BEEF);
        applyStimulus(32'h1200_0020, 32'h0000_1234, 1'b1);
        checkOutput("leds_oow_store", {16'b0, LEDS}, 32'h0000_BEEF);
        applyStimulus(ioAddr(IO_SW_OFS), 32'h0000_1111, 1'b1);
        readCheck("sw_readonly", ioAddr(IO_SW_OFS), 32'h0000_A5C3);

`ifdef OTTER_IO_TIMER_EN
        // Compare timer with auto-reload and interrupt enabled.
        applyStimulus(ioAddr(IO_TCMP_OFS), 32'd5, 1'b1);
        readCheck("tcmp_read", ioAddr(IO_TCMP_OFS), 32'd5);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'h7, 1'b1);
        idle(5);
        checkOutput("intr_before_match", {31'b0, INTR}, 32'h0);
        idle(1);
        checkOutput("intr_match", {31'b0, INTR}, 32'h1);
        readCheck("tcnt_reloaded", ioAddr(IO_TCNT_OFS), 32'h0);
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h1, 1'b1);
        checkOutput("intr_w1c", {31'b0, INTR}, 32'h0);
        idle(3);
        checkOutput("intr_before_refire", {31'b0, INTR}, 32'h0);
        idle(1);
        checkOutput("intr_refire", {31'b0, INTR}, 32'h1);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'h0, 1'b1);
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h1, 1'b1);
        checkOutput("intr_stopped", {31'b0, INTR}, 32'h0);

        // Wrap from FFFF_FFFF, no auto-reload, interrupt masked.
        applyStimulus(ioAddr(IO_TCMP_OFS), 32'd3, 1'b1);
        applyStimulus(ioAddr(IO_TCNT_OFS), 32'hFFFF_FFFF, 1'b1);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'h1, 1'b1);
        readCheck("wrap_start", ioAddr(IO_TCNT_OFS), 32'hFFFF_FFFF);
        readCheck("wrap_zero", ioAddr(IO_TCNT_OFS), 32'h0);
        readCheck("wrap_one", ioAddr(IO_TCNT_OFS), 32'h1);
        readCheck("tpend_cnt2", ioAddr(IO_STAT_OFS), 32'h0);
        readCheck("tpend_cnt3", ioAddr(IO_STAT_OFS), 32'h0);
        readCheck("tpend_set", ioAddr(IO_STAT_OFS), 32'h1);
        checkOutput("intr_masked", {31'b0, INTR}, 32'h0);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'h0, 1'b1);
`else
        // Timer absent: its registers read 0 and only BIE is writable.
        applyStimulus(ioAddr(IO_TCMP_OFS), 32'd5, 1'b1);
        readCheck("tcmp_absent", ioAddr(IO_TCMP_OFS), 32'h0);
        applyStimulus(ioAddr(IO_TCNT_OFS), 32'd9, 1'b1);
        readCheck("tcnt_absent", ioAddr(IO_TCNT_OFS), 32'h0);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'hF, 1'b1);
        readCheck("ctrl_bie_only", ioAddr(IO_CTRL_OFS), 32'h8);
        checkOutput("intr_no_timer", {31'b0, INTR}, 32'h0);
`endif

        // Button interrupt: pending appears 3 cycles after the rise.
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h0000_00F1, 1'b1);
        applyStimulus(ioAddr(IO_CTRL_OFS), 32'h8, 1'b1);
        checkOutput("btn_intr_idle", {31'b0, INTR}, 32'h0);
        BTN = 4'b0100;
        idle(2);
        checkOutput("btn_intr_early", {31'b0, INTR}, 32'h0);
        idle(1);
        checkOutput("btn_intr", {31'b0, INTR}, 32'h1);
        readCheck("btn_status", ioAddr(IO_STAT_OFS), 32'h0000_0040);

        // W1C in the same cycle as a fresh edge leaves the bit set.
        BTN = 4'b0000;
        idle(3);
        BTN = 4'b0100;
        idle(2);
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h0000_0040, 1'b1);
        readCheck("btn_w1c_race", ioAddr(IO_STAT_OFS), 32'h0000_0040);
        applyStimulus(ioAddr(IO_STAT_OFS), 32'h0000_0040, 1'b1);
        readCheck("btn_w1c", ioAddr(IO_STAT_OFS), 32'h0);
        checkOutput("btn_intr_cleared", {31'b0, INTR}, 32'h0);

        // Mid-operation asynchronous reset with INTR high.
`ifdef OTTER_IO_TIMER_EN
        applyStimulus(ioAddr(IO_TCNT_OFS), 32'd100, 1'b1);
        readCheck("tcnt_loaded", ioAddr(IO_TCNT_OFS), 32'd100);
`endif
        BTN = 4'b0110;
        idle(3);
        readCheck("leds_before_reset", ioAddr(IO_LED_OFS), 32'h0000_BEEF);
        checkOutput("intr_before_reset", {31'b0, INTR}, 32'h1);
        #2;
        RESET = 1'b1;
        BTN   = 4'b0000;
        #1;
        checkOutput("async_reset_intr", {31'b0, INTR}, 32'h0);
        checkOutput("async_reset_leds", {16'b0, LEDS}, 32'h0);
        checkOutput("async_reset_iobus_in", IOBUS_IN, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
`ifdef OTTER_IO_TIMER_EN
        readCheck("async_reset_tcnt", ioAddr(IO_TCNT_OFS), 32'h0);
`endif
        readCheck("after_reset_status", ioAddr(IO_STAT_OFS), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_io_responder.md
# otter_io_responder

Memory-mapped I/O responder on the OTTER MCU's IOBUS, the far end of the CPU's `IOBUS_ADDR`/`IOBUS_OUT`/`IOBUS_WR`/`IOBUS_IN` interface. It decodes CPU loads and stores in the I/O window and exposes switches and buttons as inputs, LEDs as outputs, and a 32-bit compare timer. It also drives the CPU's `INTR` input from a latched, maskable pending-event register.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h1100_0000`: I/O window base. Only `ADDR[31:8]` is compared.
- `PRESCALE`, default `1`: CLK cycles per timer tick. Range is 1 to 65535.

Ports:
- `CLK` input, 1 bit: system clock.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `IOBUS_ADDR` input, 32 bits: byte address from the CPU MEM stage.
- `IOBUS_OUT` input, 32 bits: store data from the CPU.
- `IOBUS_WR` input, 1 bit: store strobe, sampled on the CLK rising edge.
- `IOBUS_IN` output, 32 bits: registered read data.
- `SWITCHES` input, 16 bits: asynchronous board switches.
- `BTN` input, 4 bits: asynchronous board buttons.
- `LEDS` output, 16 bits: LED register.
- `INTR` output, 1 bit: level interrupt request to the CPU.

## Operation
- Decode: the window is hit when `IOBUS_ADDR[31:8] == BASE_ADDR[31:8]`. `ADDR[7:2]` selects the word and `ADDR[1:0]` is ignored. Writes are full-word only.
- Register map (byte offsets):
  - 0x00 SWITCHES: read-only. Returns the synchronized `{16'b0, SWITCHES}`.
  - 0x04 BUTTONS: read-only. Returns the synchronized `{28'b0, BTN}`.
  - 0x20 LEDS: read/write, bits [15:0].
  - 0x40 TCMP: read/write, 32-bit compare value.
  - 0x44 TCNT: read/write, 32-bit count. A write loads the count.
  - 0x48 CTRL: read/write.
    - bit0 `TEN`: timer enable.
    - bit1 `TAR`: auto-reload to 0 on match.
    - bit2 `TIE`: timer IRQ enable.
    - bit3 `BIE`: button IRQ enable.
  - 0x4C STATUS: read / write-1-to-clear.
    - bit0 `TPEND`: timer match pending.
    - bits [7:4] `BPEND`: per-button rising-edge pending.
- Unmapped offsets and out-of-window addresses read 0. Writes to them are ignored, as are writes to read-only registers.
- Synchronizers: `SWITCHES` and `BTN` each pass through 2 flops. A button rising edge is detected as the synchronized value being 1 now and 0 on the previous cycle.
- Timer:
  - The prescaler counts 0 to `PRESCALE-1` while `TEN=1`. The timer ticks when the prescaler is at `PRESCALE-1`; on that cycle the prescaler returns to 0 and `TCNT` increments.
  - `TCNT` wraps from `32'hFFFF_FFFF` to 0.
  - Match occurs when a tick happens and the pre-increment `TCNT` equals `TCMP`. On match, `TPEND` is set. If `TAR=1`, `TCNT` becomes 0 instead of incrementing.
  - Clearing `TEN` freezes `TCNT` and resets the prescaler to 0.
- `INTR` is `(TPEND & TIE) | (|BPEND & BIE)`. It is combinational from flops, so it is glitch-free.
- Simultaneous events:
  - A set event and a W1C of the same STATUS bit in the same cycle: the bit stays set.
  - A TCNT write and a tick in the same cycle: the written value wins. A match on that cycle is still evaluated on the old count.
  - Pending bits latch even when their enable bit is 0. Masking affects only `INTR`.

## Timing
- Read latency is 1 cycle. `IOBUS_IN` is registered from the address presented in cycle N and is valid in cycle N+1, matching the synchronous data-memory latency in the CPU. The register updates every cycle regardless of `IOBUS_WR`.
- A store takes effect at the edge where `IOBUS_WR=1`. A read of the same register in the next cycle returns the new value.
- Pending-bit sets appear on the edge after the triggering event. `INTR` rises in the same cycle the bit becomes visible.
- A button edge sets `BPEND` 3 cycles after the `BTN` transition: 2 synchronizer cycles plus 1 edge-detect cycle.
- Reset values:
  - Outputs: `IOBUS_IN=0`, `LEDS=0`, `INTR=0`.
  - Registers: TCMP=0, TCNT=0, CTRL=0, STATUS=0, prescaler=0.
  - Synchronizer and edge flops: 0.
- If `RESET` is asserted mid-count, all state clears immediately (asynchronously). No match fires on the release edge.

## Configuration
- `OTTER_IO_TIMER_EN` defined: the timer, TCMP, TCNT, `CTRL[2:0]` and `TPEND` are built.
- Not defined:
  - Offsets 0x40 and 0x44 read 0 and ignore writes.
  - `CTRL[2:0]` and `STATUS[0]` read 0.
  - `INTR` is driven only by buttons.
  - No timer flops are instantiated.

## Structure
- Shared package `otter_io_pkg`:
  - Offset constants: `IO_SW_OFS`, `IO_BTN_OFS`, `IO_LED_OFS`, `IO_TCMP_OFS`, `IO_TCNT_OFS`, `IO_CTRL_OFS`, `IO_STAT_OFS`.
  - CTRL bit-index constants.
  - A packed struct `io_ctrl_t` for CTRL.
- Sub-module `otter_io_timer` holds the prescaler, TCNT, match detection and the load port. It sits inside the `OTTER_IO_TIMER_EN` guard.

## Test plan
- Reset, then set SWITCHES=16'hA5C3 and read 0x1100_0000 → `IOBUS_IN` is `32'h0000_A5C3` one cycle after the address (after synchronization settles).
- Store `32'h0000_BEEF` to 0x1100_0020 → `LEDS=16'hBEEF` on the next cycle. A read returns `32'h0000_BEEF`. A store to 0x1200_0020 leaves `LEDS` unchanged.
- TCMP=5, CTRL=4'b0111, PRESCALE=1 → TPEND and `INTR` rise 6 ticks after enable and TCNT restarts at 0. Writing 1 to 0x4C clears `INTR`, and it re-fires 6 ticks later.
- Hold BTN[2] high with BIE=1 → STATUS=`32'h40` and `INTR=1` 3 cycles after the rise. A W1C of bit 6 issued on the same cycle as a new edge leaves the bit set.
- TCNT=`32'hFFFF_FFFF`, TCMP=3, TAR=0 → the count wraps to 0. TPEND sets on the tick where the old count is 3.
- Assert RESET while TCNT=100 with `INTR` high → `INTR`, `LEDS`, `IOBUS_IN` and TCNT are 0 before the next CLK edge.
